// File: rtl/dff_en_reg.sv
// dff_en_reg
//
// Purpose:
//   Parameterised-width storage register with a write enable and an
//   asynchronous active-low reset to a configurable constant. It is the
//   basic state-holding primitive for datapath and control registers.
//   A write loads i on the rising clock edge. Without a write, the stored
//   value holds. Data is stored bit-exact; no arithmetic is performed.
//
// Parameters:
//   width_p     - data width in bits (>= 1)
//   reset_val_p - value loaded on reset. Bits above width_p are dropped,
//                 and narrower values are zero-extended.
//
// Ports:
//   clk_i      in   1        clock, rising-edge active
//   rst_i      in   1        asynchronous reset, active-low (0 = in reset)
//   w_v_i      in   1        write valid; loads i on the next rising edge
//   i          in   width_p  write data
//   o          out  width_p  stored data, driven straight from the flops
//   par_err_o  out  1        parity error flag (DFF_EN_REG_PARITY_EN only)
//
// Configuration macro:
//   DFF_EN_REG_PARITY_EN - when defined, an extra stored bit holds the even
//   parity of the written data. par_err_o flags any single-bit upset of
//   the stored state. When undefined, neither the parity bit nor
//   par_err_o exists.
//
// Reset release is not synchronised here. The integrator must synchronise
// rst_i deassertion to clk_i externally.

module dff_en_reg #(
  parameter int unsigned width_p     = 16,
  parameter              reset_val_p = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               w_v_i,
  input  logic [width_p-1:0] i,
`ifdef DFF_EN_REG_PARITY_EN
  output logic [width_p-1:0] o,
  output logic               par_err_o
`else
  output logic [width_p-1:0] o
`endif
);

  // The size cast truncates wide reset constants and zero-extends narrow ones,
  // so any integer reset_val_p maps onto exactly width_p bits.
  localparam logic [width_p-1:0] reset_val_lp = width_p'(reset_val_p);

  logic [width_p-1:0] data_q;

  // Storage flops. Reset is asynchronous and takes priority over a write in
  // the same cycle. With no write, the register simply holds its value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= reset_val_lp;
    end else if (w_v_i) begin
      data_q <= i;
    end
  end

  assign o = data_q;

`ifdef DFF_EN_REG_PARITY_EN
  localparam logic reset_par_lp = ^reset_val_lp;

  logic par_q;

  // The parity bit shares the data write condition. It therefore always
  // describes the word currently held in data_q. Its reset value is the
  // parity of the reset constant, so the flag stays clear out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      par_q <= reset_par_lp;
    end else if (w_v_i) begin
      par_q <= ^i;
    end
  end

  // Recomputed from the stored state, not from i. An upset in either the
  // data flops or the parity flop shows up here.
  assign par_err_o = (^data_q) ^ par_q;
`endif

endmodule

// File: tb/tb_dff_en_reg.sv
// tb_dff_en_reg
//
// Purpose:
//   Self-checking bench for dff_en_reg with width_p = 16 and reset_val_p = 5.
//   Directed vectors carry hand-computed expectations. A random stream is
//   checked against a one-register reference model. When
//   DFF_EN_REG_PARITY_EN is defined, the parity flag is also exercised.

`timescale 1ns/1ps

module tb_dff_en_reg;

  localparam int unsigned WIDTH = 16;
  localparam logic [WIDTH-1:0] RESET_VAL = 16'h0005;

  logic             clk_i;
  logic             rst_i;
  logic             w_v_i;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] o;
`ifdef DFF_EN_REG_PARITY_EN
  logic             par_err_o;
`endif

  int vectorCount;
  int missCount;

  dff_en_reg #(
    .width_p    (WIDTH),
    .reset_val_p(5)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .w_v_i    (w_v_i),
    .i        (i),
`ifdef DFF_EN_REG_PARITY_EN
    .o        (o),
    .par_err_o(par_err_o)
`else
    .o        (o)
`endif
  );

  // Free-running 10 ns clock. Rising edges occur at 5, 15, 25, ...
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Every comparison goes through this task. It counts the comparison and
  // reports any mismatch on one line.
  task automatic checkOutput(input string tag,
                             input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives inputs on the falling edge, away from the active edge. It then
  // waits for the next rising edge and settles 1 ns before the caller samples.
  task automatic applyStimulus(input logic rst, input logic wv,
                               input logic [WIDTH-1:0] data);
    @(negedge clk_i);
    rst_i = rst;
    w_v_i = wv;
    i     = data;
    @(posedge clk_i);
    #1;
  endtask

  logic [WIDTH-1:0] modelQ;
  logic             randW;
  logic [WIDTH-1:0] randD;

  initial begin
    vectorCount = 0;
    missCount   = 0;
    rst_i = 1'b1;
    w_v_i = 1'b0;
    i     = '0;

    // Assert reset at 2 ns, before any clock edge has occurred.
    #2 rst_i = 1'b0;
    #1;
    checkOutput("async_reset_no_clock", o, RESET_VAL);

    // Hold reset low while trying to write all ones for three edges.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 16'hFFFF);
      checkOutput("reset_blocks_write", o, RESET_VAL);
    end

    // Release reset and write on the first edge after release.
    applyStimulus(1'b1, 1'b1, 16'hA5A5);
    checkOutput("first_write_after_release", o, 16'hA5A5);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    checkOutput("hold_without_write", o, 16'hA5A5);

    // Back-to-back writes on consecutive edges.
    applyStimulus(1'b1, 1'b1, 16'h0001);
    checkOutput("b2b_write_1", o, 16'h0001);
    applyStimulus(1'b1, 1'b1, 16'h0002);
    checkOutput("b2b_write_2", o, 16'h0002);
    applyStimulus(1'b1, 1'b1, 16'h0003);
    checkOutput("b2b_write_3", o, 16'h0003);
    applyStimulus(1'b1, 1'b0, 16'hFFFF);
    checkOutput("hold_after_b2b", o, 16'h0003);

    // Mid-operation async reset, asserted between clock edges.
    applyStimulus(1'b1, 1'b1, 16'hBEEF);
    checkOutput("write_beef", o, 16'hBEEF);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("midop_async_reset", o, RESET_VAL);
    applyStimulus(1'b1, 1'b1, 16'h0007);
    checkOutput("write_after_midop_reset", o, 16'h0007);

    // Random stream checked against a single-register model.
    modelQ = 16'h0007;
    for (int k = 0; k < 1000; k++) begin
      randW = 1'($urandom_range(0, 1));
      randD = 16'($urandom);
      applyStimulus(1'b1, randW, randD);
      if (randW) modelQ = randD;
      checkOutput("random_stream", o, modelQ);
    end

    // After a reset with no later writes, the model value is the reset constant.
    applyStimulus(1'b0, 1'b1, 16'h5555);
    checkOutput("reset_with_write_same_edge", o, RESET_VAL);
    applyStimulus(1'b1, 1'b0, 16'h5555);
    checkOutput("hold_reset_value_after_release", o, RESET_VAL);

`ifdef DFF_EN_REG_PARITY_EN
    checkOutput("par_err_after_reset", {15'd0, par_err_o}, 16'h0000);
    applyStimulus(1'b1, 1'b1, 16'h0003);
    checkOutput("par_err_clean_write", {15'd0, par_err_o}, 16'h0000);
    // Flip bit 0 of the stored word (0003 -> 0002) to model an upset.
    force dut.data_q = 16'h0002;
    #1;
    checkOutput("par_err_upset", {15'd0, par_err_o}, 16'h0001);
    release dut.data_q;
    applyStimulus(1'b1, 1'b1, 16'h0003);
    checkOutput("par_err_cleared_by_write", {15'd0, par_err_o}, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
